instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 172 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer for stalls, branch redirect.
// Optional performance counter output fetch_count is enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [0:31] branch_target,
    output logic [0:31] imem_addr,
    output logic        imem_rd_en,
    input  logic [0:31] imem_data,
    output logic [0:31] instruction,
    output logic [0:31] pc_out,
    output logic        if_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [0:31] fetch_count
`endif
);

    localparam logic [0:31] NOP_WORD = 32'hF000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [0:31] pc_q, pc_d;
    logic [0:31] addr_q, addr_d;
    logic [0:31] instr_q, instr_d;
    logic [0:31] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [0:31] skid_data_q, skid_data_d;
    logic [0:31] skid_addr_q, skid_addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [0:31] imem_addr_s;
    logic        imem_rd_en_s;
    logic [0:31] target_s;

    assign target_s = {branch_target[0:29], 2'b00};

    // Next-state and memory-request logic; a branch overrides any stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_data_d  = skid_data_q;
        skid_addr_d  = skid_addr_q;
        skid_valid_d = skid_valid_q;
        imem_addr_s  = pc_q;
        imem_rd_en_s = 1'b0;
        if (reset) begin
            imem_addr_s  = 32'd0;
            imem_rd_en_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    imem_rd_en_s = 1'b1;
                    addr_d       = pc_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = RUN;
                end
                RUN, HOLD: begin
                    if (branch_taken) begin
                        imem_addr_s  = target_s;
                        imem_rd_en_s = 1'b1;
                        addr_d       = target_s;
                        pc_d         = target_s + 32'd4;
                        skid_valid_d = 1'b0;
                        instr_d      = NOP_WORD;
                        pc_out_d     = 32'd0;
                        valid_d      = 1'b0;
                        state_d      = RUN;
                    end else if (stall) begin
                        // Park the word already in flight so it is not lost while held.
                        if (state_q == RUN) begin
                            skid_data_d  = imem_data;
                            skid_addr_d  = addr_q;
                            skid_valid_d = 1'b1;
                            state_d      = HOLD;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        if (state_q == RUN) begin
                            instr_d  = imem_data;
                            pc_out_d = addr_q;
                            valid_d  = 1'b1;
                        end else begin
                            instr_d      = skid_data_q;
                            pc_out_d     = skid_addr_q;
                            valid_d      = skid_valid_q;
                            skid_valid_d = 1'b0;
                        end
                        imem_rd_en_s = 1'b1;
                        addr_d       = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            addr_q       <= 32'd0;
            instr_q      <= NOP_WORD;
            pc_out_q     <= 32'd0;
            valid_q      <= 1'b0;
            skid_data_q  <= 32'd0;
            skid_addr_q  <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_data_q  <= skid_data_d;
            skid_addr_q  <= skid_addr_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imem_addr   = imem_addr_s;
    assign imem_rd_en  = imem_rd_en_s;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign if_valid    = valid_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [0:31] cnt_q, cnt_d;
    logic        deliver_s;

    // A new word is delivered whenever a non-IDLE cycle sees neither branch nor stall.
    assign deliver_s = (state_q != IDLE) && !branch_taken && !stall;

    // Delivery counter next value; wraps naturally.
    always_comb begin
        if (deliver_s) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Delivery counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, random traffic against a sequence model.
module tb_instruction_fetch;

    localparam logic [0:31] NOP = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [0:31] branch_target = 32'd0;
    logic [0:31] imem_addr;
    logic        imem_rd_en;
    logic [0:31] imem_data = 32'd0;
    logic [0:31] instruction;
    logic [0:31] pc_out;
    logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [0:31] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    // Model: the fetch stream is just "next address to deliver"; no skid or states.
    bit          m_first = 1'b1;
    logic [0:31] m_next = 32'd0;
    logic [0:31] m_instr = NOP;
    logic [0:31] m_pc = 32'd0;
    logic        m_valid = 1'b0;
    logic [0:31] m_cnt = 32'd0;

    instruction_fetch dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_addr(imem_addr),
        .imem_rd_en(imem_rd_en),
        .imem_data(imem_data),
        .instruction(instruction),
        .pc_out(pc_out),
        .if_valid(if_valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory returns address/4 one cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= imem_addr >> 2;
        else            imem_data <= $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [0:31] t,
                        output logic act_rd, output logic [0:31] act_addr);
        logic [0:31] at;
        logic        erd;
        logic [0:31] ea;
        reset = r; stall = s; branch_taken = b; branch_target = t;
        at = {t[0:29], 2'b00};
        @(negedge clk);
        if (r)            begin erd = 1'b0; ea = 32'd0; end
        else if (m_first) begin erd = 1'b1; ea = 32'd0; end
        else if (b)       begin erd = 1'b1; ea = at; end
        else if (s)       begin erd = 1'b0; ea = 32'd0; end
        else              begin erd = 1'b1; ea = m_next + 32'd4; end
        act_rd = imem_rd_en;
        act_addr = imem_addr;
        chk("model_rd_en", {31'd0, imem_rd_en}, {31'd0, erd});
        if (erd || r) chk("model_imem_addr", imem_addr, ea);
        @(posedge clk);
        #1;
        if (r) begin
            m_first = 1'b1; m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
        end else if (m_first) begin
            m_first = 1'b0; m_next = 32'd0;
        end else if (b) begin
            m_next = at; m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = m_next >> 2; m_pc = m_next; m_valid = 1'b1;
            m_next = m_next + 32'd4; m_cnt = m_cnt + 32'd1;
        end
        chk("model_instruction", instruction, m_instr);
        chk("model_pc_out", pc_out, m_pc);
        chk("model_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
`ifdef IFETCH_PERF_CNT_EN
        chk("model_fetch_count", fetch_count, m_cnt);
`endif
    endtask

    typedef struct {
        logic        r, s, b;
        logic [0:31] t;
        logic        erd;
        logic [0:31] ea;
        logic [0:31] ei, ep;
        logic        ev;
    } vec_t;

    vec_t        vt[25];
    logic        ard;
    logic [0:31] aad;

    initial begin
        //                r     s     b     target          rd    addr            instr           pc_out          valid
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h40,         1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 32'h40,         1'b1, 32'h0,          NOP,            32'h0,          1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h4,          32'h0,          32'h0,          1'b1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h8,          32'h1,          32'h4,          1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h1,          32'h4,          1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h1,          32'h4,          1'b1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h1,          32'h4,          1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'hC,          32'h2,          32'h8,          1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h10,         32'h3,          32'hC,          1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b1, 32'h102,        1'b1, 32'h100,        NOP,            32'h0,          1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h104,        32'h40,         32'h100,        1'b1};
        vt[12] = '{1'b0, 1'b1, 1'b1, 32'h200,        1'b1, 32'h200,        NOP,            32'h0,          1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[14] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h204,        32'h80,         32'h200,        1'b1};
        vt[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFC,  NOP,            32'h0,          1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          32'h3FFF_FFFF,  32'hFFFF_FFFC,  1'b1};
        vt[18] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h4,          32'h0,          32'h0,          1'b1};
        vt[19] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          32'h0,          1'b1};
        vt[20] = '{1'b0, 1'b0, 1'b1, 32'h10,         1'b1, 32'h10,         NOP,            32'h0,          1'b0};
        vt[21] = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[22] = '{1'b1, 1'b1, 1'b1, 32'h80,         1'b0, 32'h0,          NOP,            32'h0,          1'b0};
        vt[23] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          NOP,            32'h0,          1'b0};
        vt[24] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h4,          32'h0,          32'h0,          1'b1};

        for (int i = 0; i < 25; i++) begin
            step(vt[i].r, vt[i].s, vt[i].b, vt[i].t, ard, aad);
            chk($sformatf("vec%0d_rd_en", i), {31'd0, ard}, {31'd0, vt[i].erd});
            if (vt[i].erd || vt[i].r) chk($sformatf("vec%0d_imem_addr", i), aad, vt[i].ea);
            chk($sformatf("vec%0d_instruction", i), instruction, vt[i].ei);
            chk($sformatf("vec%0d_pc_out", i), pc_out, vt[i].ep);
            chk($sformatf("vec%0d_if_valid", i), {31'd0, if_valid}, {31'd0, vt[i].ev});
        end

        // Long stall, then a branch with stall in the following cycle, then reset mid-branch.
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0, ard, aad);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0333, ard, aad);
        for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 1'b0, 32'h0, ard, aad);
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0500, ard, aad);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0600, ard, aad);
        step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);

`ifdef IFETCH_PERF_CNT_EN
        // Ten deliveries with an interleaved stall and branch, then reset clears the count.
        step(1'b1, 1'b0, 1'b0, 32'h0, ard, aad);
        step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 32'h0, ard, aad);
        step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0700, ard, aad);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, ard, aad);
        chk("perf_count_ten", fetch_count, 32'd10);
        step(1'b1, 1'b0, 1'b0, 32'h0, ard, aad);
        chk("perf_count_reset", fetch_count, 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        rr, rs, rb;
            logic [0:31] rt;
            rr = ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 2) == 0);
            rb = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom());
            step(rr, rs, rb, rt, ard, aad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
